ysyx_22040175_lsu: RTL and testbench

Parametrised load/store unit with integrated data SRAM: the next-generation replacement for the single-cycle combinational data memory. Sits beside the CPU core and exchanges valid/ready requests and responses, so the core can stall on memory. Supports byte, half, word and optional double accesses with byte strobes, sign/zero extension, programmable access latency, and alignment and range error reporting.

---
 rtl/ysyx_22040175_lsu_pkg.sv | 27 ++
 rtl/ysyx_22040175_sram.sv | 38 +++
 rtl/ysyx_22040175_lsu.sv | 220 ++++++++++++++++++++++
 tb/tb_ysyx_22040175_lsu.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040175_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040175_lsu_pkg
// Description : Shared encodings for the load/store unit: access sizes,
//               FSM states and latency counter sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22040175_lsu_pkg;

  // Access size encodings carried on req_size
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Largest supported access latency and the counter width needed for it
  localparam int c_max_latency = 15;
  localparam int c_cnt_w       = $clog2(c_max_latency + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/ysyx_22040175_sram.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040175_sram
// Description : Single-port data SRAM, synchronous byte-strobed write,
//               combinational read. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040175_sram #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [XLEN/8-1:0]        strb,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [XLEN-1:0]          wdata,
  output logic [XLEN-1:0]          rdata
);

  localparam int c_nbytes = XLEN / 8;

  logic [XLEN-1:0] r_mem [DEPTH];

  // Byte-lane write: only strobed bytes of the addressed word change
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < c_nbytes; i++) begin
        if (strb[i]) begin
          r_mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/ysyx_22040175_lsu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040175_lsu
// Description : Load/store unit with integrated data SRAM. Valid/ready request
//               and response channels, byte/half/word/double accesses,
//               sign/zero extension, programmable latency, alignment and
//               range error reporting. One outstanding request at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040175_lsu
  import ysyx_22040175_lsu_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 1,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);

  localparam int                 c_nbytes   = XLEN / 8;
  localparam int                 c_lane_w   = $clog2(c_nbytes);
  localparam int                 c_idx_w    = $clog2(DEPTH);
  localparam int                 c_off_w    = c_lane_w + c_idx_w;
  localparam logic [XLEN-1:0]    c_base     = BASE_ADDR[XLEN-1:0];
  localparam logic [XLEN-1:0]    c_span     = XLEN'(DEPTH * c_nbytes);
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(LATENCY - 1);

  lsu_state_t           r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_req_ready;
  logic                 r_resp_valid;
  logic [XLEN-1:0]      r_rdata;
  logic                 r_err;
  logic                 r_we;
  logic [1:0]           r_size;
  logic                 r_unsigned;
  logic [c_off_w-1:0]   r_offset;
  logic [XLEN-1:0]      r_wdata;
  logic                 r_bad;

  logic [XLEN-1:0]      w_offset;
  logic                 w_misaligned;
  logic                 w_bad_size;
  logic                 w_out_of_range;
  logic                 w_illegal;

  logic [c_lane_w-1:0]  w_lane;
  logic [c_idx_w-1:0]   w_index;
  logic [c_lane_w+2:0]  w_shamt;
  logic [c_nbytes-1:0]  w_size_strb;
  logic [c_nbytes-1:0]  w_strb;
  logic [XLEN-1:0]      w_mem_wdata;
  logic [XLEN-1:0]      w_mem_rdata;
  logic                 w_mem_we;
  logic [XLEN-1:0]      w_shifted;
  logic [XLEN-1:0]      w_keep;
  logic                 w_sign;
  logic [XLEN-1:0]      w_load_data;

  // ---------------------------------------------------------------------------
  // Request legality, evaluated on the raw request so it can be latched at
  // acceptance. Addresses below the base wrap to a huge offset and fail range.
  // ---------------------------------------------------------------------------
  assign w_offset       = req_addr - c_base;
  assign w_bad_size     = (req_size == SZ_D) && (XLEN == 32);
  assign w_out_of_range = (w_offset >= c_span);
  assign w_illegal      = w_misaligned || w_bad_size || w_out_of_range;

  // Natural alignment check per access size
  always_comb begin
    w_misaligned = 1'b0;
    case (req_size)
      SZ_H:    w_misaligned = req_addr[0];
      SZ_W:    w_misaligned = |req_addr[1:0];
      SZ_D:    w_misaligned = |req_addr[2:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Access datapath, driven from the latched request
  // ---------------------------------------------------------------------------
  assign w_lane      = r_offset[c_lane_w-1:0];
  assign w_index     = r_offset[c_off_w-1:c_lane_w];
  assign w_shamt     = {w_lane, 3'b000};
  assign w_strb      = w_size_strb << w_lane;
  assign w_mem_wdata = r_wdata << w_shamt;
  assign w_mem_we    = (r_state == ST_WAIT) && (r_cnt == '0) && r_we && !r_bad;
  assign w_shifted   = w_mem_rdata >> w_shamt;

  // Byte-count mask of the access before it is moved to its lane
  always_comb begin
    w_size_strb = '1;
    case (r_size)
      SZ_B:    w_size_strb = c_nbytes'(4'b0001);
      SZ_H:    w_size_strb = c_nbytes'(4'b0011);
      SZ_W:    w_size_strb = c_nbytes'(4'b1111);
      default: w_size_strb = '1;
    endcase
  end

  // Bits kept by the load and the sign bit used to fill the rest
  always_comb begin
    w_keep = '1;
    w_sign = 1'b0;
    case (r_size)
      SZ_B: begin
        w_keep = XLEN'(8'hFF);
        w_sign = w_shifted[7];
      end
      SZ_H: begin
        w_keep = XLEN'(16'hFFFF);
        w_sign = w_shifted[15];
      end
      SZ_W: begin
        w_keep = XLEN'(32'hFFFF_FFFF);
        w_sign = w_shifted[31];
      end
      default: begin
        w_keep = '1;
        w_sign = 1'b0;
      end
    endcase
  end

  assign w_load_data = (r_unsigned || !w_sign) ? (w_shifted & w_keep)
                                               : (w_shifted | ~w_keep);

  ysyx_22040175_sram #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_sram (
    .clk   (clk),
    .we    (w_mem_we),
    .strb  (w_strb),
    .addr  (w_index),
    .wdata (w_mem_wdata),
    .rdata (w_mem_rdata)
  );

  // ---------------------------------------------------------------------------
  // Control FSM with registered handshake and response outputs. Illegal
  // requests spend one cycle in WAIT with the counter at zero so every error
  // response arrives one cycle after acceptance, and they never touch the SRAM.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_we         <= 1'b0;
      r_size       <= SZ_B;
      r_unsigned   <= 1'b0;
      r_offset     <= '0;
      r_wdata      <= '0;
      r_bad        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_size      <= req_size;
            r_unsigned  <= req_unsigned;
            r_offset    <= w_offset[c_off_w-1:0];
            r_wdata     <= req_wdata;
            r_bad       <= w_illegal;
            r_cnt       <= w_illegal ? '0 : c_cnt_init;
            r_req_ready <= 1'b0;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_resp_valid <= 1'b1;
            r_err        <= r_bad;
            r_rdata      <= (r_we || r_bad) ? '0 : w_load_data;
            r_state      <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - c_cnt_w'(1);
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040175_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22040175_lsu
// Description : Directed self-checking bench for ysyx_22040175_lsu. Three
//               instances: defaults, LATENCY=4, and XLEN=64.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040175_lsu;
  import ysyx_22040175_lsu_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // Instance A: XLEN=32, LATENCY=1
  logic        a_req_valid, a_req_ready, a_req_we, a_req_unsigned;
  logic [1:0]  a_req_size;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic        a_resp_valid, a_resp_ready, a_resp_err;
  // Instance B: XLEN=32, LATENCY=4
  logic        b_req_valid, b_req_ready, b_req_we, b_req_unsigned;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
  logic        b_resp_valid, b_resp_ready, b_resp_err;
  // Instance C: XLEN=64, LATENCY=1
  logic        c_req_valid, c_req_ready, c_req_we, c_req_unsigned;
  logic [1:0]  c_req_size;
  logic [63:0] c_req_addr, c_req_wdata, c_resp_rdata;
  logic        c_resp_valid, c_resp_ready, c_resp_err;

  ysyx_22040175_lsu u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_size(a_req_size), .req_unsigned(a_req_unsigned), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  ysyx_22040175_lsu #(.LATENCY(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_size(b_req_size), .req_unsigned(b_req_unsigned), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  ysyx_22040175_lsu #(.XLEN(64)) u_dut_c (
    .clk(clk), .rst(rst),
    .req_valid(c_req_valid), .req_ready(c_req_ready), .req_we(c_req_we),
    .req_size(c_req_size), .req_unsigned(c_req_unsigned), .req_addr(c_req_addr),
    .req_wdata(c_req_wdata), .resp_valid(c_resp_valid), .resp_ready(c_resp_ready),
    .resp_rdata(c_resp_rdata), .resp_err(c_resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One transaction on instance A (l4=0) or B (l4=1); lat counts edges from
  // acceptance to resp_valid (capped, so a missing response shows as a bad lat)
  task automatic req32(input bit l4, input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    if (l4) begin
      b_req_valid = 1'b1; b_req_we = we; b_req_size = sz; b_req_unsigned = uns;
      b_req_addr = addr; b_req_wdata = wd;
    end else begin
      a_req_valid = 1'b1; a_req_we = we; a_req_size = sz; a_req_unsigned = uns;
      a_req_addr = addr; a_req_wdata = wd;
    end
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    lat = 0;
    while (!(l4 ? b_resp_valid : a_resp_valid) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = l4 ? b_resp_rdata : a_resp_rdata;
    er = l4 ? b_resp_err : a_resp_err;
    if (l4) b_resp_ready = 1'b1; else a_resp_ready = 1'b1;
    @(posedge clk); #1;
    a_resp_ready = 1'b0;
    b_resp_ready = 1'b0;
  endtask

  task automatic req64(input bit we, input logic [1:0] sz, input bit uns,
                       input logic [63:0] addr, input logic [63:0] wd,
                       output logic [63:0] rd, output logic er, output int lat);
    @(negedge clk);
    c_req_valid = 1'b1; c_req_we = we; c_req_size = sz; c_req_unsigned = uns;
    c_req_addr = addr; c_req_wdata = wd;
    @(posedge clk); #1;
    c_req_valid = 1'b0;
    lat = 0;
    while (!c_resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = c_resp_rdata;
    er = c_resp_err;
    c_resp_ready = 1'b1;
    @(posedge clk); #1;
    c_resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready: got %b expected 1", a_req_ready); end
    checks++; if (a_resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid: got %b expected 0", a_resp_valid); end
    checks++; if (a_resp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata: got %h expected 0", a_resp_rdata); end
    checks++; if (a_resp_err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b expected 0", a_resp_err); end
    checks++; if (c_resp_rdata !== 64'h0) begin failures++; $display("FAIL rst_rdata64: got %h expected 0", c_resp_rdata); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (b_req_ready !== 1'b1 || b_resp_valid !== 1'b0) begin failures++; $display("FAIL rst_release_b: got ready=%b valid=%b expected ready=1 valid=0", b_req_ready, b_resp_valid); end
  endtask

  task automatic test_defaults();
    logic [31:0] rd; logic er; int lat;
    req32(0, 1, SZ_W, 0, 32'h8000_0010, 32'hDEAD_BEEF, rd, er, lat);
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL store_word: got err=%b rdata=%h expected err=0 rdata=0", er, rd); end
    checks++; if (lat != 1) begin failures++; $display("FAIL store_latency: got %0d expected 1", lat); end
    req32(0, 0, SZ_W, 0, 32'h8000_0010, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin failures++; $display("FAIL load_word: got %h err=%b expected deadbeef err=0", rd, er); end
    checks++; if (lat != 1) begin failures++; $display("FAIL load_latency: got %0d expected 1", lat); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic er; int lat;
    req32(0, 1, SZ_B, 0, 32'h8000_0013, 32'h5555_5580, rd, er, lat);
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL store_byte_err: got %b expected 0", er); end
    req32(0, 0, SZ_B, 0, 32'h8000_0013, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_signed: got %h expected ffffff80", rd); end
    req32(0, 0, SZ_B, 1, 32'h8000_0013, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000_0080) begin failures++; $display("FAIL lb_unsigned: got %h expected 00000080", rd); end
    req32(0, 0, SZ_W, 0, 32'h8000_0010, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h80AD_BEEF) begin failures++; $display("FAIL lw_after_sb: got %h expected 80adbeef", rd); end
    req32(0, 0, SZ_H, 0, 32'h8000_0012, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFF_80AD) begin failures++; $display("FAIL lh_signed: got %h expected ffff80ad", rd); end
    req32(0, 0, SZ_H, 1, 32'h8000_0010, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000_BEEF) begin failures++; $display("FAIL lh_unsigned: got %h expected 0000beef", rd); end
    req32(0, 1, SZ_H, 0, 32'h8000_0010, 32'hAAAA_1234, rd, er, lat);
    req32(0, 0, SZ_W, 0, 32'h8000_0010, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h80AD_1234) begin failures++; $display("FAIL lw_after_sh: got %h expected 80ad1234", rd); end
    req32(0, 0, SZ_B, 0, 32'h8000_0011, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000_0012) begin failures++; $display("FAIL lb_lane1: got %h expected 00000012", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] e_addr [8];
    logic [1:0]  e_size [8];
    logic        e_we   [8];
    e_addr = '{32'h8000_0001, 32'h8000_0002, 32'h8000_1000, 32'h7FFF_FFFC,
               32'h8000_0000, 32'h8000_1000, 32'h8000_0012, 32'h7FFF_FFFC};
    e_size = '{SZ_H, SZ_W, SZ_W, SZ_W, SZ_D, SZ_W, SZ_W, SZ_W};
    e_we   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    // Neighbouring words that an erroneous store would hit if it leaked
    req32(0, 1, SZ_W, 0, 32'h8000_0000, 32'h0BAD_F00D, rd, er, lat);
    req32(0, 1, SZ_W, 0, 32'h8000_0FFC, 32'hCAFE_F00D, rd, er, lat);
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL last_word_store_err: got %b expected 0", er); end
    for (int i = 0; i < 8; i++) begin
      req32(0, e_we[i], e_size[i], 0, e_addr[i], 32'hFFFF_FFFF, rd, er, lat);
      checks++; if (er !== 1'b1 || rd !== 32'h0 || lat != 1) begin failures++; $display("FAIL err_case%0d: got err=%b rdata=%h lat=%0d expected err=1 rdata=0 lat=1", i, er, rd, lat); end
    end
    req32(0, 0, SZ_W, 0, 32'h8000_0000, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0BAD_F00D) begin failures++; $display("FAIL err_no_write_w0: got %h expected 0badf00d", rd); end
    req32(0, 0, SZ_W, 0, 32'h8000_0010, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h80AD_1234) begin failures++; $display("FAIL err_no_write_w4: got %h expected 80ad1234", rd); end
    req32(0, 0, SZ_W, 0, 32'h8000_0FFC, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin failures++; $display("FAIL last_word_load: got %h err=%b expected cafef00d err=0", rd, er); end
    req32(0, 0, SZ_B, 1, 32'h8000_0FFF, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000_00CA || er !== 1'b0) begin failures++; $display("FAIL last_byte_load: got %h err=%b expected 000000ca err=0", rd, er); end
  endtask

  task automatic test_latency_backpressure();
    logic [31:0] rd; logic er; int lat;
    req32(1, 1, SZ_W, 0, 32'h8000_0000, 32'h1122_3344, rd, er, lat);
    checks++; if (lat != 4 || er !== 1'b0) begin failures++; $display("FAIL l4_store: got lat=%0d err=%b expected lat=4 err=0", lat, er); end
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_size = SZ_W; b_req_unsigned = 1'b0;
    b_req_addr = 32'h8000_0000; b_req_wdata = 32'h0;
    @(posedge clk); #1;
    // Keep a conflicting store on the request port; it must be ignored
    b_req_we = 1'b1; b_req_wdata = 32'hFFFF_FFFF;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      checks++; if (b_resp_valid !== 1'b0 || b_req_ready !== 1'b0) begin failures++; $display("FAIL l4_early%0d: got valid=%b ready=%b expected valid=0 ready=0", i, b_resp_valid, b_req_ready); end
    end
    @(posedge clk); #1;
    checks++; if (b_resp_valid !== 1'b1 || b_resp_rdata !== 32'h1122_3344 || b_resp_err !== 1'b0) begin failures++; $display("FAIL l4_resp: got valid=%b rdata=%h err=%b expected 1 11223344 0", b_resp_valid, b_resp_rdata, b_resp_err); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (b_resp_valid !== 1'b1 || b_resp_rdata !== 32'h1122_3344 || b_req_ready !== 1'b0) begin failures++; $display("FAIL l4_hold%0d: got valid=%b rdata=%h ready=%b expected 1 11223344 0", i, b_resp_valid, b_resp_rdata, b_req_ready); end
    end
    b_resp_ready = 1'b1;
    @(posedge clk); #1;
    b_resp_ready = 1'b0;
    b_req_valid = 1'b0;
    checks++; if (b_resp_valid !== 1'b0 || b_req_ready !== 1'b1) begin failures++; $display("FAIL l4_handshake: got valid=%b ready=%b expected valid=0 ready=1", b_resp_valid, b_req_ready); end
    req32(1, 0, SZ_W, 0, 32'h8000_0000, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h1122_3344) begin failures++; $display("FAIL l4_ignored_req: got %h expected 11223344", rd); end
  endtask

  task automatic test_reset_during_wait();
    logic [31:0] rd; logic er; int lat;
    req32(1, 1, SZ_W, 0, 32'h8000_0020, 32'h0, rd, er, lat);
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_size = SZ_W; b_req_unsigned = 1'b0;
    b_req_addr = 32'h8000_0020; b_req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (b_resp_valid !== 1'b0 || b_req_ready !== 1'b1) begin failures++; $display("FAIL rst_wait_async: got valid=%b ready=%b expected valid=0 ready=1", b_resp_valid, b_req_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (b_resp_valid !== 1'b0) begin failures++; $display("FAIL rst_wait_no_resp: got %b expected 0", b_resp_valid); end
    req32(1, 0, SZ_W, 0, 32'h8000_0020, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0 || lat != 4) begin failures++; $display("FAIL rst_wait_no_write: got rdata=%h lat=%0d expected 0 4", rd, lat); end
  endtask

  task automatic test_xlen64();
    logic [63:0] rd; logic er; int lat;
    req64(1, SZ_D, 0, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, rd, er, lat);
    checks++; if (er !== 1'b0 || lat != 1) begin failures++; $display("FAIL sd_64: got err=%b lat=%0d expected 0 1", er, lat); end
    req64(0, SZ_H, 0, 64'h8000_000E, 64'h0, rd, er, lat);
    checks++; if (rd !== 64'h0000_0000_0000_0123) begin failures++; $display("FAIL lh_64: got %h expected 0000000000000123", rd); end
    req64(0, SZ_W, 0, 64'h8000_0008, 64'h0, rd, er, lat);
    checks++; if (rd !== 64'hFFFF_FFFF_89AB_CDEF) begin failures++; $display("FAIL lw_64_signed: got %h expected ffffffff89abcdef", rd); end
    req64(0, SZ_W, 1, 64'h8000_0008, 64'h0, rd, er, lat);
    checks++; if (rd !== 64'h0000_0000_89AB_CDEF) begin failures++; $display("FAIL lw_64_unsigned: got %h expected 0000000089abcdef", rd); end
    req64(0, SZ_W, 0, 64'h8000_000C, 64'h0, rd, er, lat);
    checks++; if (rd !== 64'h0000_0000_0123_4567) begin failures++; $display("FAIL lw_64_upper: got %h expected 0000000001234567", rd); end
    req64(0, SZ_D, 0, 64'h8000_0008, 64'h0, rd, er, lat);
    checks++; if (rd !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL ld_64: got %h expected 0123456789abcdef", rd); end
    req64(0, SZ_D, 0, 64'h8000_0004, 64'h0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 64'h0 || lat != 1) begin failures++; $display("FAIL ld_64_misaligned: got err=%b rdata=%h lat=%0d expected 1 0 1", er, rd, lat); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    a_req_valid = 0; a_req_we = 0; a_req_size = SZ_B; a_req_unsigned = 0;
    a_req_addr = '0; a_req_wdata = '0; a_resp_ready = 0;
    b_req_valid = 0; b_req_we = 0; b_req_size = SZ_B; b_req_unsigned = 0;
    b_req_addr = '0; b_req_wdata = '0; b_resp_ready = 0;
    c_req_valid = 0; c_req_we = 0; c_req_size = SZ_B; c_req_unsigned = 0;
    c_req_addr = '0; c_req_wdata = '0; c_resp_ready = 0;
    test_reset();
    test_defaults();
    test_byte_lanes();
    test_errors();
    test_latency_backpressure();
    test_reset_during_wait();
    test_xlen64();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
